// File: rtl/mac_tx_arbiter_if.sv
// Bundle of requester-side and MAC raw TX-side signals for mac_tx_arbiter.
// The master modport drives requests, source words and MAC backpressure.
interface mac_tx_arbiter_if #(
    parameter int unsigned N_REQ = 2
);
    logic [N_REQ-1:0]    req;
    logic [N_REQ*32-1:0] src_data;
    logic [N_REQ-1:0]    src_sof;
    logic [N_REQ-1:0]    src_eof;
    logic [N_REQ-1:0]    src_we;
    logic [N_REQ-1:0]    gnt;
    logic [N_REQ-1:0]    src_stop;
    logic [31:0]         tx_raw_data;
    logic                tx_raw_sof;
    logic                tx_raw_we;
    logic                tx_raw_stop;

    modport master (
        output req, src_data, src_sof, src_eof, src_we, tx_raw_stop,
        input  gnt, src_stop, tx_raw_data, tx_raw_sof, tx_raw_we
    );

    modport slave (
        input  req, src_data, src_sof, src_eof, src_we, tx_raw_stop,
        output gnt, src_stop, tx_raw_data, tx_raw_sof, tx_raw_we
    );
endinterface

// File: rtl/mac_tx_arbiter.sv
// Round-robin arbiter granting one frame requester at a time onto the MAC raw TX port,
// with an idle watchdog that aborts stalled grants and a mandatory one-cycle gap.
module mac_tx_arbiter #(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                 usr_clk,
    input  logic                 reset_n,
    mac_tx_arbiter_if.slave      bus,
    output logic                 busy,
    output logic [15:0]          frame_count,
    output logic [7:0]           timeout_count
);
    localparam int unsigned IW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] w_gnt_nxt;
    logic [IW-1:0]    r_last;
    logic [IW-1:0]    w_last_nxt;
    logic [15:0]      r_wdog;
    logic [15:0]      r_frame_cnt;
    logic [7:0]       r_tout_cnt;

    logic [IW-1:0]    w_sel_idx;
    logic             w_sel_found;
    logic [31:0]      w_mux_data;
    logic             w_in_grant;
    logic             w_we_g;
    logic             w_sof_g;
    logic             w_eof_g;
    logic             w_acc;
    logic             w_eof_acc;
    logic             w_expire;

    // Two passes give "first requester after last winner" without modulo indexing.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = r_last;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!w_sel_found && bus.req[i] && (i > 32'(r_last))) begin
                w_sel_found = 1'b1;
                w_sel_idx   = IW'(i);
            end
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!w_sel_found && bus.req[i] && (i <= 32'(r_last))) begin
                w_sel_found = 1'b1;
                w_sel_idx   = IW'(i);
            end
        end
    end

    always_comb begin
        w_mux_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (r_gnt[i]) begin
                w_mux_data = bus.src_data[i*32 +: 32];
            end
        end
    end

    assign w_in_grant = (r_state == GRANT);
    assign w_we_g     = |(bus.src_we  & r_gnt);
    assign w_sof_g    = |(bus.src_sof & r_gnt);
    assign w_eof_g    = |(bus.src_eof & r_gnt);
    assign w_acc      = w_in_grant & w_we_g & ~bus.tx_raw_stop;
    assign w_eof_acc  = w_acc & w_eof_g;
    assign w_expire   = w_in_grant && (r_wdog == 16'(TIMEOUT - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_last_nxt  = r_last;
        case (r_state)
            IDLE: begin
                if (w_sel_found) begin
                    w_gnt_nxt   = N_REQ'(1) << w_sel_idx;
                    w_last_nxt  = w_sel_idx;
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (w_eof_acc || w_expire) begin
                    w_gnt_nxt   = '0;
                    w_state_nxt = GAP;
                end
            end
            GAP: begin
                w_gnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_gnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge usr_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_last  <= IW'(N_REQ - 1);
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Watchdog sits at zero outside GRANT, so GRANT entry always starts from a clean count.
    always_ff @(posedge usr_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wdog <= '0;
        end else if (w_in_grant && !w_acc) begin
            r_wdog <= r_wdog + 16'd1;
        end else begin
            r_wdog <= '0;
        end
    end

    // eof on the expiry cycle counts as a completed frame, not an abort.
    always_ff @(posedge usr_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_cnt <= '0;
            r_tout_cnt  <= '0;
        end else begin
            if (w_eof_acc) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if (w_expire && !w_eof_acc && (r_tout_cnt != 8'hFF)) begin
                r_tout_cnt <= r_tout_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        bus.gnt         = r_gnt;
        bus.src_stop    = {N_REQ{bus.tx_raw_stop}} | ~r_gnt;
        bus.tx_raw_data = w_in_grant ? w_mux_data : '0;
        bus.tx_raw_sof  = w_in_grant & w_sof_g;
        bus.tx_raw_we   = w_acc;
        busy            = (r_state != IDLE);
        frame_count     = r_frame_cnt;
        timeout_count   = r_tout_cnt;
    end
endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Randomized bench for mac_tx_arbiter: a cycle model predicts grants and accepted words,
// a scoreboard queue holds the expected MAC word stream, and a monitor checks the DUT.
module tb_mac_tx_arbiter;
    localparam int unsigned N  = 3;
    localparam int unsigned TO = 16;

    logic        usr_clk = 1'b0;
    logic        reset_n;
    logic        busy;
    logic [15:0] frame_count;
    logic [7:0]  timeout_count;

    mac_tx_arbiter_if #(.N_REQ(N)) bus ();

    mac_tx_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .usr_clk       (usr_clk),
        .reset_n       (reset_n),
        .bus           (bus),
        .busy          (busy),
        .frame_count   (frame_count),
        .timeout_count (timeout_count)
    );

    always #5 usr_clk = ~usr_clk;

    typedef struct {
        logic [31:0] data;
        logic        sof;
    } word_t;

    word_t sb[$];
    int    total = 0;
    int    bad   = 0;

    // Reference model: who owns the port, whether the gap cycle is pending, arbitration history.
    int owner;
    int last;
    int idle;
    int frames;
    int touts;
    bit gap;

    logic [N-1:0] e_gnt;
    logic [N-1:0] e_stop;
    logic         e_we;
    logic         e_sof;
    logic         e_busy;
    logic [31:0]  e_data;
    logic [15:0]  e_fc;
    logic [7:0]   e_tc;
    bit           chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner  = -1;
        last   = N - 1;
        idle   = 0;
        frames = 0;
        touts  = 0;
        gap    = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},  bus.gnt, '0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_we"},   bus.tx_raw_we, 0);
        check({tag, "_sof"},  bus.tx_raw_sof, 0);
        check({tag, "_data"}, bus.tx_raw_data, 0);
        check({tag, "_fc"},   frame_count, 0);
        check({tag, "_tc"},   timeout_count, 0);
    endtask

    // Expected outputs for the current cycle, then advance the model across the next edge.
    task automatic model_step();
        bit granted;
        bit acc;
        granted = (owner >= 0);
        e_gnt   = granted ? (N'(1) << owner) : '0;
        e_stop  = bus.tx_raw_stop ? '1 : ~e_gnt;
        acc     = granted && bus.src_we[owner] && !bus.tx_raw_stop;
        e_we    = acc;
        e_data  = granted ? bus.src_data[owner*32 +: 32] : 32'd0;
        e_sof   = granted ? bus.src_sof[owner] : 1'b0;
        e_busy  = granted || gap;
        e_fc    = 16'(frames);
        e_tc    = 8'(touts);
        if (acc) sb.push_back('{data: e_data, sof: e_sof});

        if (granted) begin
            if (acc && bus.src_eof[owner]) begin
                frames = (frames + 1) % 65536;
                owner  = -1;
                gap    = 1'b1;
            end else if (idle == TO - 1) begin
                if (touts < 255) touts++;
                owner = -1;
                gap   = 1'b1;
            end else begin
                idle = acc ? 0 : idle + 1;
            end
        end else if (gap) begin
            gap = 1'b0;
        end else if (bus.req != '0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (last + k) % N;
                if (owner < 0 && bus.req[c]) begin
                    owner = c;
                    last  = c;
                    idle  = 0;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge usr_clk);
            #2;
            if (chk_en) begin
                check("gnt",      bus.gnt, e_gnt);
                check("src_stop", bus.src_stop, e_stop);
                check("we",       bus.tx_raw_we, e_we);
                check("busy",     busy, e_busy);
                check("fc",       frame_count, e_fc);
                check("tc",       timeout_count, e_tc);
                if (e_gnt == '0) begin
                    check("idle_data", bus.tx_raw_data, 0);
                    check("idle_sof",  bus.tx_raw_sof, 0);
                end
                if (bus.tx_raw_we === 1'b1) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_pop: got unexpected word %0h want none", bus.tx_raw_data);
                    end else begin
                        word_t w;
                        w = sb.pop_front();
                        check("sb_data", bus.tx_raw_data, w.data);
                        check("sb_sof",  bus.tx_raw_sof, w.sof);
                    end
                end
            end
        end
    end

    initial begin
        bit did_rst;
        int we_pct;
        int eof_pct;
        int stop_pct;
        did_rst          = 1'b0;
        reset_n          = 1'b0;
        bus.req          = '0;
        bus.src_data     = '0;
        bus.src_sof      = '0;
        bus.src_eof      = '0;
        bus.src_we       = '0;
        bus.tx_raw_stop  = 1'b0;
        model_reset();
        repeat (3) @(negedge usr_clk);
        #1;
        check_reset_outputs("rst0");

        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge usr_clk);
            reset_n = 1'b1;
            we_pct   = (cyc >= 2000 && cyc < 3500) ? 8 : 75;
            eof_pct  = 25;
            stop_pct = (cyc >= 4000) ? 70 : 20;
            for (int i = 0; i < N; i++) begin
                bus.req[i]               = ($urandom_range(0, 99) < 70);
                bus.src_we[i]            = ($urandom_range(0, 99) < we_pct);
                bus.src_sof[i]           = ($urandom_range(0, 99) < 25);
                bus.src_eof[i]           = ($urandom_range(0, 99) < eof_pct);
                bus.src_data[i*32 +: 32] = $urandom;
            end
            bus.tx_raw_stop = ($urandom_range(0, 99) < stop_pct);
            if (cyc >= 100 && cyc < 110) begin
                bus.src_we       = '1;
                bus.src_sof      = '1;
                bus.src_eof      = '1;
                bus.tx_raw_stop  = 1'b0;
                bus.src_data     = {N{32'hDEADBEEF}};
            end
            chk_en = 1'b1;
            if (!did_rst && cyc > 1000 && owner >= 0) begin
                did_rst = 1'b1;
                model_step();
                #3;
                reset_n = 1'b0;
                #1;
                check_reset_outputs("rst_mid");
                model_reset();
                sb.delete();
            end else begin
                model_step();
            end
        end

        @(negedge usr_clk);
        #3;
        chk_en = 1'b0;
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
